// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute/write-back sequencer for the
// lab CPU datapath. It decodes the 5-bit opcode held in the IR and drives the
// IR, PC and register-file strobes and the ALU selects. It also keeps a
// saturating count of retired instructions.
//
// Build option: define SEQ_SINGLE_STEP_EN to let a step pulse start one
// instruction from IDLE. When it is undefined, only run leaves IDLE.
//
// The opcode input comes from the IR. The IR is loaded in FETCH and holds its
// value through DECODE, EXECUTE and WRITEBACK, so the opcode is decoded
// combinationally in every state and is never copied into a local register.

module cpu_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [4:0]       opcode,
    input  logic             eq_flag,
    input  logic             rd_is_zero,
    output logic             ir_load,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             rf_we,
    output logic [1:0]       alu_op,
    output logic             alu_src_imm,
    output logic             halted,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [4:0] OP_BEQ  = 5'b00100;
    localparam logic [4:0] OP_JUMP = 5'b00101;
    localparam logic [4:0] OP_HALT = 5'b11111;

`ifdef SEQ_SINGLE_STEP_EN
    localparam logic STEP_EN = 1'b1;
`else
    localparam logic STEP_EN = 1'b0;
`endif

    logic [2:0]       state_reg;
    logic [2:0]       state_next;
    logic [CNT_W-1:0] retired_reg;
    logic             is_alu;
    logic [1:0]       dec_alu_op;
    logic             dec_alu_src_imm;
    logic             retire;
    logic             step_go;

    // The step pulse counts only when single-step support is built in.
    assign step_go = step & STEP_EN;

    // Opcode classification: opcodes 00000-00011 are the ALU group.
    always_comb begin
        is_alu          = (opcode[4:2] == 3'b000);
        dec_alu_op      = 2'b00;
        dec_alu_src_imm = 1'b0;
        case (opcode[1:0])
            2'b00: begin dec_alu_op = 2'b00; dec_alu_src_imm = 1'b0; end // ADD
            2'b01: begin dec_alu_op = 2'b01; dec_alu_src_imm = 1'b1; end // SUBI
            2'b10: begin dec_alu_op = 2'b00; dec_alu_src_imm = 1'b1; end // ADDI
            default: begin dec_alu_op = 2'b10; dec_alu_src_imm = 1'b0; end // SHIFTL
        endcase
    end

    // Retirement happens in WRITEBACK for ALU ops.
    // It happens in EXECUTE for branches, jumps and NOPs.
    assign retire = (state_reg == S_WRITEBACK) ||
                    ((state_reg == S_EXECUTE) && !is_alu);

    // State register; reset returns to IDLE at once, cancelling any pending strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state sequencing through the instruction phases.
    always_comb begin
        state_next = S_IDLE;
        case (state_reg)
            S_IDLE:      state_next = (run || step_go) ? S_FETCH : S_IDLE;
            S_FETCH:     state_next = S_DECODE;
            S_DECODE:    state_next = (opcode == OP_HALT) ? S_HALT : S_EXECUTE;
            S_EXECUTE: begin
                if (is_alu) begin
                    state_next = S_WRITEBACK;
                end else begin
                    state_next = run ? S_FETCH : S_IDLE;
                end
            end
            S_WRITEBACK: state_next = run ? S_FETCH : S_IDLE;
            S_HALT:      state_next = S_HALT;
            default:     state_next = S_IDLE;
        endcase
    end

    // Retired-instruction counter; it saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_reg <= '0;
        end else if (retire && (retired_reg != {CNT_W{1'b1}})) begin
            retired_reg <= retired_reg + 1'b1;
        end
    end

    // Datapath strobes and selects, decoded straight from the state and opcode.
    always_comb begin
        ir_load     = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 1'b0;
        rf_we       = 1'b0;
        alu_op      = 2'b00;
        alu_src_imm = 1'b0;
        halted      = 1'b0;
        case (state_reg)
            S_FETCH: ir_load = 1'b1;
            S_EXECUTE: begin
                if (is_alu) begin
                    alu_op      = dec_alu_op;
                    alu_src_imm = dec_alu_src_imm;
                end else if (opcode == OP_BEQ) begin
                    pc_en  = 1'b1;
                    pc_sel = eq_flag;
                end else if (opcode == OP_JUMP) begin
                    pc_en  = 1'b1;
                    pc_sel = 1'b1;
                end else begin
                    pc_en  = 1'b1;
                    pc_sel = 1'b0;
                end
            end
            S_WRITEBACK: begin
                alu_op      = dec_alu_op;
                alu_src_imm = dec_alu_src_imm;
                rf_we       = !rd_is_zero;
                pc_en       = 1'b1;
                pc_sel      = 1'b0;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign busy    = (state_reg != S_IDLE) && (state_reg != S_HALT);
    assign state   = state_reg;
    assign retired = retired_reg;

endmodule
